// File: rtl/contra_pkg.sv
// Shared keycode constants, game-state encodings and input-filter types
// for the frame-rate game blocks.
package contra_pkg;

   localparam logic [7:0] KEY_NONE  = 8'h00;
   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   localparam logic [1:0] GS_MENU = 2'd0;
   localparam logic [1:0] GS_PLAY = 2'd1;
   localparam logic [1:0] GS_OVER = 2'd2;

   typedef enum logic [1:0] {IDLE, ARMING, HELD} in_state_t;
   typedef enum {NONE, MOVE, FIRE} key_class_t;

   function automatic key_class_t classify_key(input logic [7:0] kc);
      key_class_t cls;
      cls = NONE;
      if (kc == KEY_W || kc == KEY_A || kc == KEY_S || kc == KEY_D) cls = MOVE;
      else if (kc == KEY_SPACE) cls = FIRE;
      return cls;
   endfunction

endpackage

// File: rtl/player_input_filter_if.sv
// Keycode-in / filtered-controls-out bundle between the NIOS PIO side and
// the player input filter.
interface player_input_filter_if;
   logic [7:0] keycode_raw;
   logic [1:0] gameState;
   logic [7:0] keycode;
   logic       fire;
   logic       frame_tick;

   modport master (
      output keycode_raw,
      output gameState,
      input  keycode,
      input  fire,
      input  frame_tick
   );

   modport slave (
      input  keycode_raw,
      input  gameState,
      output keycode,
      output fire,
      output frame_tick
   );
endinterface

// File: rtl/vsync_edge_detect.sv
// Brings an asynchronous frame-rate strobe into the Clk domain and emits a
// registered one-cycle pulse per rising edge.
module vsync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic tick
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic tick_q,  tick_d;

   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      tick_d  = sync2_q & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/player_input_filter.sv
// Gates the raw keyboard keycode by game state, debounces movement keys over
// whole frames and turns space-bar presses into rate-limited fire pulses.
module player_input_filter
   import contra_pkg::*;
#(
   parameter int unsigned DEBOUNCE_FRAMES = 3,
   parameter int unsigned FIRE_COOLDOWN   = 8,
   parameter logic [1:0]  PLAY_STATE      = GS_PLAY
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   frame_clk,
   player_input_filter_if.slave   pif
);

   localparam logic [3:0] DEB_N  = 4'(DEBOUNCE_FRAMES);
   localparam logic [7:0] COOL_N = 8'(FIRE_COOLDOWN);

   logic       frame_tick;
   key_class_t key_class;

   in_state_t  state_q, state_d;
   logic [7:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] keycode_q, keycode_d;
   logic [7:0] cooldown_q, cooldown_d;
   logic       prev_fire_q, prev_fire_d;
   logic       fire_q, fire_d;

   vsync_edge_detect u_vsync (
      .clk      (Clk),
      .rst_n    (Reset),
      .async_in (frame_clk),
      .tick     (frame_tick)
   );

   always_comb begin
      key_class   = classify_key(pif.keycode_raw);
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      keycode_d   = keycode_q;
      cooldown_d  = cooldown_q;
      prev_fire_d = prev_fire_q;
      fire_d      = 1'b0;

      // Leaving play wipes all progress so a key still held must re-debounce.
      if (pif.gameState != PLAY_STATE) begin
         state_d     = IDLE;
         cnt_d       = 4'd0;
         keycode_d   = KEY_NONE;
         cooldown_d  = 8'd0;
         prev_fire_d = 1'b0;
      end else if (frame_tick) begin
         case (state_q)
            IDLE: begin
               if (key_class == MOVE) begin
                  cand_d = pif.keycode_raw;
                  cnt_d  = 4'd1;
                  if (DEB_N == 4'd1) begin
                     state_d   = HELD;
                     keycode_d = pif.keycode_raw;
                  end else begin
                     state_d = ARMING;
                  end
               end
            end
            ARMING: begin
               if (key_class == MOVE && pif.keycode_raw == cand_q) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q + 4'd1 == DEB_N) begin
                     state_d   = HELD;
                     keycode_d = cand_q;
                  end
               end else if (key_class == MOVE) begin
                  cand_d = pif.keycode_raw;
                  cnt_d  = 4'd1;
               end else begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
               end
            end
            HELD: begin
               if (key_class == MOVE && pif.keycode_raw != cand_q) begin
                  cand_d = pif.keycode_raw;
                  cnt_d  = 4'd1;
                  // A single-frame debounce has nothing to arm, so switch at once.
                  if (DEB_N == 4'd1) begin
                     keycode_d = pif.keycode_raw;
                  end else begin
                     state_d   = ARMING;
                     keycode_d = KEY_NONE;
                  end
               end else if (key_class != MOVE) begin
                  state_d   = IDLE;
                  cnt_d     = 4'd0;
                  keycode_d = KEY_NONE;
               end
            end
            default: begin
               state_d   = IDLE;
               cnt_d     = 4'd0;
               keycode_d = KEY_NONE;
            end
         endcase

         // Firing needs a fresh press edge and an expired cooldown.
         if (key_class == FIRE && !prev_fire_q && cooldown_q == 8'd0) begin
            fire_d     = 1'b1;
            cooldown_d = COOL_N;
         end else if (cooldown_q != 8'd0) begin
            cooldown_d = cooldown_q - 8'd1;
         end
         prev_fire_d = (key_class == FIRE);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         cand_q      <= KEY_NONE;
         cnt_q       <= 4'd0;
         keycode_q   <= KEY_NONE;
         cooldown_q  <= 8'd0;
         prev_fire_q <= 1'b0;
         fire_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         keycode_q   <= keycode_d;
         cooldown_q  <= cooldown_d;
         prev_fire_q <= prev_fire_d;
         fire_q      <= fire_d;
      end
   end

   assign pif.keycode    = keycode_q;
   assign pif.fire       = fire_q;
   assign pif.frame_tick = frame_tick;

endmodule

// File: tb/tb_player_input_filter.sv
// Directed bench for player_input_filter: each frame pushes the expected
// filtered outputs to a scoreboard that is popped once the DUT has updated.
module tb_player_input_filter;
   import contra_pkg::*;

   logic Clk = 1'b0;
   logic Reset;
   logic frame_clk;

   player_input_filter_if bus ();

   player_input_filter #(
      .DEBOUNCE_FRAMES (3),
      .FIRE_COOLDOWN   (8),
      .PLAY_STATE      (2'd1)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .pif       (bus.slave)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0] key;
      logic       fire;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One frame: apply a keycode, raise frame_clk, wait for the tick, compare.
   task automatic frame(input logic [7:0] raw, input logic [7:0] exp_key,
                        input logic exp_fire, input string tag);
      exp_t e;
      exp_t got;
      int   cyc;
      @(negedge Clk);
      bus.keycode_raw = raw;
      e.key  = exp_key;
      e.fire = exp_fire;
      e.tag  = tag;
      sb.push_back(e);
      frame_clk = 1'b1;
      cyc = 0;
      do begin
         @(posedge Clk);
         #1;
         cyc++;
      end while (bus.frame_tick !== 1'b1 && cyc < 10);
      check({tag, " tick_latency"}, 8'(cyc), 8'd3);
      @(posedge Clk);
      #1;
      check({tag, " tick_width"}, {7'd0, bus.frame_tick}, 8'd0);
      got = sb.pop_front();
      check({got.tag, " keycode"}, bus.keycode, got.key);
      check({got.tag, " fire"}, {7'd0, bus.fire}, {7'd0, got.fire});
      @(posedge Clk);
      #1;
      check({tag, " fire_width"}, {7'd0, bus.fire}, 8'd0);
      @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset           = 1'b0;
      frame_clk       = 1'b0;
      bus.keycode_raw = KEY_NONE;
      bus.gameState   = GS_PLAY;
      @(posedge Clk);
      #1;
      check("reset keycode", bus.keycode, 8'h00);
      check("reset fire", {7'd0, bus.fire}, 8'd0);
      check("reset frame_tick", {7'd0, bus.frame_tick}, 8'd0);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);

      // Movement debounce from IDLE
      frame(KEY_W, 8'h00, 1'b0, "w1");
      frame(KEY_W, 8'h00, 1'b0, "w2");
      frame(KEY_W, 8'h1A, 1'b0, "w3");
      frame(KEY_W, 8'h1A, 1'b0, "w4");

      // Key change while held re-arms
      frame(KEY_D, 8'h00, 1'b0, "d1");
      frame(KEY_D, 8'h00, 1'b0, "d2");
      frame(KEY_D, 8'h07, 1'b0, "d3");
      frame(KEY_D, 8'h07, 1'b0, "d4");
      frame(KEY_A, 8'h00, 1'b0, "a1");
      frame(KEY_A, 8'h00, 1'b0, "a2");
      frame(KEY_A, 8'h04, 1'b0, "a3");
      frame(KEY_NONE, 8'h00, 1'b0, "release_a");

      // Non-game keys are ignored
      for (int i = 0; i < 3; i++) frame(8'h29, 8'h00, 1'b0, "esc");
      for (int i = 0; i < 2; i++) frame(8'h1B, 8'h00, 1'b0, "key1b");

      // Holding space fires once
      for (int i = 0; i < 12; i++) frame(KEY_SPACE, 8'h00, (i == 0), "space_hold");
      frame(KEY_NONE, 8'h00, 1'b0, "space_release");

      // Cooldown blocks a press at tick 5, allows one at tick 11
      frame(KEY_SPACE, 8'h00, 1'b1, "cd_t1");
      for (int i = 0; i < 3; i++) frame(KEY_NONE, 8'h00, 1'b0, "cd_rel_a");
      frame(KEY_SPACE, 8'h00, 1'b0, "cd_t5");
      for (int i = 0; i < 5; i++) frame(KEY_NONE, 8'h00, 1'b0, "cd_rel_b");
      frame(KEY_SPACE, 8'h00, 1'b1, "cd_t11");

      // Game-state gate drops held key and clears cooldown
      frame(KEY_S, 8'h00, 1'b0, "s1");
      frame(KEY_S, 8'h00, 1'b0, "s2");
      frame(KEY_S, 8'h16, 1'b0, "s3");
      @(negedge Clk);
      bus.gameState = GS_OVER;
      @(posedge Clk);
      #1;
      check("gate keycode", bus.keycode, 8'h00);
      check("gate fire", {7'd0, bus.fire}, 8'd0);
      @(negedge Clk);
      bus.gameState = GS_PLAY;
      frame(KEY_S, 8'h00, 1'b0, "s_re1");
      frame(KEY_S, 8'h00, 1'b0, "s_re2");
      frame(KEY_S, 8'h16, 1'b0, "s_re3");
      frame(KEY_SPACE, 8'h00, 1'b1, "fire_after_gate");
      frame(KEY_NONE, 8'h00, 1'b0, "release_fire");

      // Reset mid-ARMING restarts the debounce
      frame(KEY_W, 8'h00, 1'b0, "arm1");
      frame(KEY_W, 8'h00, 1'b0, "arm2");
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check("midreset keycode", bus.keycode, 8'h00);
      check("midreset fire", {7'd0, bus.fire}, 8'd0);
      check("midreset frame_tick", {7'd0, bus.frame_tick}, 8'd0);
      @(negedge Clk);
      Reset = 1'b1;
      frame(KEY_W, 8'h00, 1'b0, "post_rst1");
      frame(KEY_W, 8'h00, 1'b0, "post_rst2");
      frame(KEY_W, 8'h1A, 1'b0, "post_rst3");

      // Asynchronous clear while HELD
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check("held_reset keycode", bus.keycode, 8'h00);
      @(negedge Clk);
      Reset = 1'b1;
      frame(KEY_NONE, 8'h00, 1'b0, "final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
